// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC, FSM encoding and queue entry type for the fetch sequencer
package fetch_pkg;
  localparam int FETCH_ADDR_W   = 6;
  localparam int FETCH_DATA_W   = 32;
  localparam int FETCH_RESET_PC = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry FIFO with push/pop/flush; flush beats push, head is a stored register
module fetch_queue #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= !rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and imem fetch sequencer feeding decode through a 2-entry queue
// Optional perf counters (stall / flush) enabled by defining FETCH_PERF_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int DATA_W   = FETCH_DATA_W,
  parameter int RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  output logic              busy
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);
  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   tag;
  logic                outstanding;
  logic                drop;

  logic                gnt_fire;
  logic                resp;
  logic                pop;
  logic                push;
  logic                set_drop;
  logic [ADDR_W+DATA_W-1:0] q_head;
  logic                q_full;
  logic                q_empty;
  logic [1:0]          q_count;

  // Requests depend only on registered state so a redirect can never glitch them.
  assign imem_req  = (state == S_RUN) && !outstanding
                     && (({1'b0, q_count} + {2'b00, outstanding}) < 3'd2);
  assign imem_addr = pc;
  assign gnt_fire  = imem_req && imem_gnt;
  assign resp      = imem_rvalid && outstanding;
  assign if_valid  = !q_empty;
  assign pop       = if_valid && if_ready;
  assign push      = resp && !drop;
  assign set_drop  = gnt_fire || (outstanding && !imem_rvalid);
  assign if_pc     = q_head[ADDR_W+DATA_W-1:DATA_W];
  assign if_instr  = q_head[DATA_W-1:0];
  assign busy      = outstanding || !q_empty;

  fetch_queue #(.W(ADDR_W + DATA_W)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({tag, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= PC0;
      tag         <= PC0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (!start) state <= S_DRAIN;
        S_DRAIN: begin
          if (start) state <= S_RUN;
          else if (!outstanding) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (redirect_valid) pc <= redirect_addr;
      else if (gnt_fire) pc <= pc + ADDR_W'(1);

      if (gnt_fire) tag <= pc;

      if (gnt_fire) outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;

      // A response landing in the redirect cycle is killed by the flush, so drop targets only later ones.
      if (redirect_valid && set_drop) drop <= 1'b1;
      else if (resp) drop <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (!reset)
    !(push && q_full && !pop && !redirect_valid));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= 16'd0;
      perf_flush_cnt <= 16'd0;
    end else begin
      if (if_valid && !if_ready && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (redirect_valid && ((q_count > {1'b0, pop}) || set_drop) && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized bench for fetch_sequencer against a queue-based reference model
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [5:0]  redirect_addr;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_pc;
  logic        if_ready;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
  int          m_stall;
  int          m_flush;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .busy           (busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: fetch address stream, in-flight flag, wrong-path drop flag, decode-visible queue.
  logic [31:0] img [64];
  int     m_pc;
  int     m_tag;
  bit     m_run;
  bit     m_out;
  bit     m_drop;
  entry_t q[$];

  // Memory model: one pending response at a time, latency lat_lo..lat_hi cycles.
  bit     mem_pend;
  int     mem_left;
  int     mem_addr;
  int     lat_lo = 1;
  int     lat_hi = 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_tag = 0; m_run = 0; m_out = 0; m_drop = 0;
    q.delete();
`ifdef FETCH_PERF_EN
    m_stall = 0; m_flush = 0;
`endif
  endtask

  task automatic cycle(input bit st, input bit rd, input int ra, input bit rdy, input int gnt_pct);
    bit exp_req, exp_valid, g, rv, pop, resp, was_out, sd;
    @(negedge clk);
    exp_req   = m_run && !m_out && (q.size() + int'(m_out) < 2);
    exp_valid = q.size() > 0;
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("if_valid", if_valid, exp_valid);
    if (exp_valid) begin
      check("if_pc", if_pc, q[0].pc);
      check("if_instr", if_instr, q[0].instr);
    end
    check("busy", busy, m_out || exp_valid);

    g  = exp_req && !mem_pend && ($urandom_range(0, 99) < gnt_pct);
    rv = mem_pend && (mem_left == 0);
    start          = st;
    redirect_valid = rd;
    redirect_addr  = 6'(ra);
    if_ready       = rdy;
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = rv ? img[mem_addr] : $urandom;

    pop     = exp_valid && rdy;
    resp    = rv && m_out;
    was_out = m_out;
    sd      = g || (was_out && !rv);
`ifdef FETCH_PERF_EN
    if (exp_valid && !rdy) m_stall++;
`endif
    if (pop) void'(q.pop_front());
`ifdef FETCH_PERF_EN
    if (rd && (q.size() > 0 || sd)) m_flush++;
`endif
    if (resp) begin
      if (m_drop) m_drop = 0;
      else if (!rd) q.push_back('{pc: 6'(m_tag), instr: img[m_tag]});
      m_out = 0;
    end
    if (g) begin
      m_out = 1;
      m_tag = m_pc;
    end
    if (rd) begin
      q.delete();
      if (sd) m_drop = 1;
      m_pc = ra;
    end else if (g) begin
      m_pc = (m_pc + 1) % 64;
    end
    m_run = st;
    if (q.size() > 2) check("queue_bound", q.size(), 2);

    if (g) begin
      mem_pend = 1;
      mem_addr = int'(imem_addr);
      mem_left = $urandom_range(lat_lo, lat_hi) - 1;
    end else if (rv) begin
      mem_pend = 0;
    end else if (mem_pend && mem_left > 0) begin
      mem_left--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_busy", busy, 1'b0);
    start = 0; redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0; if_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit st;
    for (int i = 0; i < 64; i++) img[i] = 32'(i);
    reset = 1'b0; start = 0; redirect_valid = 0; redirect_addr = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; if_ready = 0;
    mem_pend = 0; mem_left = 0; mem_addr = 0;
    model_reset();
    #3;
    check("init_imem_req", imem_req, 1'b0);
    check("init_if_valid", if_valid, 1'b0);
    check("init_if_pc", if_pc, 0);
    check("init_if_instr", if_instr, 0);
    check("init_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // In-order stream from reset with 1-cycle memory.
    repeat (16) cycle(1, 0, 0, 1, 100);
    // Wrap 62 -> 63 -> 0 -> 1.
    cycle(1, 1, 62, 1, 100);
    repeat (12) cycle(1, 0, 0, 1, 100);
    // Decode stall: queue fills, requests stop.
    repeat (12) cycle(1, 0, 0, 0, 100);
    repeat (8) cycle(1, 0, 0, 1, 100);

    // Redirect while a request is in flight.
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && !m_out; i++) cycle(1, 0, 0, 0, 100);
    check("reach_outstanding", m_out, 1'b1);
    cycle(1, 1, 20, 0, 100);
    repeat (14) cycle(1, 0, 0, 1, 100);

    // Redirect in the same cycle as a pop.
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20 && q.size() == 0; i++) cycle(1, 0, 0, 0, 100);
    check("reach_queued", q.size() > 0, 1'b1);
    cycle(1, 1, 40, 1, 100);
    repeat (10) cycle(1, 0, 0, 1, 100);

    // Redirect with start low, then stop/drain/restart.
    cycle(0, 0, 0, 1, 100);
    repeat (6) cycle(0, 0, 0, 1, 100);
    cycle(0, 1, 10, 1, 100);
    repeat (3) cycle(0, 0, 0, 1, 100);
    repeat (8) cycle(1, 0, 0, 1, 100);

    // Reset with a request outstanding; the stale response must be ignored.
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && !m_out; i++) cycle(1, 0, 0, 1, 100);
    check("reach_out_reset", m_out, 1'b1);
    do_reset();
    repeat (12) cycle(1, 0, 0, 1, 100);

    // Randomized traffic.
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    st = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1000 || n == 2000) begin
        do_reset();
        for (int i = 0; i < 64; i++) img[i] = $urandom;
      end
      if ($urandom_range(0, 99) < 3) st = !st;
      cycle(st, $urandom_range(0, 99) < 5, $urandom_range(0, 63),
            $urandom_range(0, 99) < 70, 70);
    end

`ifdef FETCH_PERF_EN
    @(negedge clk);
    check("perf_stall", perf_stall_cnt, (m_stall > 65535) ? 65535 : m_stall);
    check("perf_flush", perf_flush_cnt, (m_flush > 65535) ? 65535 : m_flush);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
